// File: rtl/mem_access_ctrl.sv
// Memory/IO access sequencer: turns one LC-3 request into a timed async-SRAM strobe
// sequence or a memory-mapped IO transfer, returning data on MDR_In and a ready pulse on R.
module mem_access_ctrl #(
  parameter int          ADDR_W      = 20,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MEM_REQ,
  input  logic              MEM_WE,
  input  logic [15:0]       MAR,
  input  logic [15:0]       MDR,
  input  logic [15:0]       S,
  input  logic [15:0]       SRAM_RDATA,
  output logic [15:0]       MDR_In,
  output logic              R,
  output logic              BUSY,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [15:0]       SRAM_WDATA,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [15:0]       HEX_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e              state_q;
  logic                armed_q;
  logic                we_q;
  logic [3:0]          cnt_q;
  logic [15:0]         mdr_in_q;
  logic [15:0]         hex_q;
  logic [15:0]         wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic                r_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic                byte_n_q;

  assign addr_d = ADDR_W'(MAR);

  // NOTE: all state is updated with non-blocking assignments so every register samples
  // pre-edge values; the reset branch is asynchronous and clears every register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      armed_q  <= 1'b1;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      mdr_in_q <= '0;
      hex_q    <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      r_q      <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      byte_n_q <= 1'b1;
    end else begin
      // Re-arm whenever the request is seen low, so one access per high period.
      if (!MEM_REQ) armed_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (MEM_REQ && armed_q) begin
            armed_q <= 1'b0;
            we_q    <= MEM_WE;
            if (MAR == IO_ADDR) begin
              state_q <= ST_DONE;
              r_q     <= 1'b1;
              if (MEM_WE) hex_q    <= MDR;
              else        mdr_in_q <= S;
            end else begin
              state_q  <= ST_SETUP;
              addr_q   <= addr_d;
              wdata_q  <= MDR;
              ce_n_q   <= 1'b0;
              byte_n_q <= 1'b0;
              oe_n_q   <= MEM_WE;
            end
          end
        end

        ST_SETUP: begin
          state_q <= ST_WAIT;
          cnt_q   <= CNT_INIT;
          we_n_q  <= ~we_q;
        end

        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= ST_DONE;
            r_q      <= 1'b1;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            byte_n_q <= 1'b1;
            if (!we_q) mdr_in_q <= SRAM_RDATA;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          r_q     <= 1'b0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MDR_In     = mdr_in_q;
  assign R          = r_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WDATA = wdata_q;
  assign SRAM_CE_N  = ce_n_q;
  assign SRAM_OE_N  = oe_n_q;
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_UB_N  = byte_n_q;
  assign SRAM_LB_N  = byte_n_q;
  assign HEX_DATA   = hex_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed transaction table, multi-cycle corner
// sequences, and randomized traffic against a cycle-count transaction model.
module tb_mem_access_ctrl;

  localparam int          ADDR_W = 20;
  localparam int          L      = 2;
  localparam logic [15:0] IO     = 16'hFFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              req, we;
  logic [15:0]       mar, mdr, s, rdata;
  logic [15:0]       mdr_in, hex;
  logic              r, busy;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic              ce_n, oe_n, we_n, ub_n, lb_n;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(L), .IO_ADDR(IO)) dut (
    .Clk(clk), .Reset(rst), .MEM_REQ(req), .MEM_WE(we), .MAR(mar), .MDR(mdr), .S(s),
    .SRAM_RDATA(rdata), .MDR_In(mdr_in), .R(r), .BUSY(busy), .SRAM_ADDR(sram_addr),
    .SRAM_WDATA(sram_wdata), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .HEX_DATA(hex)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One directed transaction with its expected outcome.
  typedef struct {
    logic        we;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] s;
    logic [15:0] rdata;
    int          lat;
    logic [15:0] exp_mdr_in;
    logic [15:0] exp_hex;
    int          ce_cyc;
    int          oe_cyc;
    int          we_cyc;
    int          first_we;
  } vec_t;

  vec_t vecs[8];

  task automatic run_txn(input vec_t v, input int idx);
    int  lat, ce_c, oe_c, we_c, fw;
    bit  got, addr_ok, wdata_ok;
    lat = 0; ce_c = 0; oe_c = 0; we_c = 0; fw = 0;
    got = 0; addr_ok = 1; wdata_ok = 1;
    req = 1'b1; we = v.we; mar = v.mar; mdr = v.mdr; s = v.s; rdata = v.rdata;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Scramble request fields after acceptance; they must be ignored.
        we = ~v.we; mar = ~v.mar; mdr = ~v.mdr;
        if (v.mar != IO) addr_ok = (sram_addr == ADDR_W'(v.mar));
      end
      if (!ce_n) ce_c++;
      if (!oe_n) oe_c++;
      if (!we_n) begin
        we_c++;
        if (fw == 0) fw = c;
      end
      if (v.we && v.mar != IO && sram_wdata != v.mdr) wdata_ok = 0;
      if (r) begin
        got = 1;
        lat = c;
      end
    end
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_mdr_in", idx), mdr_in, v.exp_mdr_in);
    check($sformatf("v%0d_hex", idx), hex, v.exp_hex);
    check($sformatf("v%0d_ce_cycles", idx), ce_c, v.ce_cyc);
    check($sformatf("v%0d_oe_cycles", idx), oe_c, v.oe_cyc);
    check($sformatf("v%0d_we_cycles", idx), we_c, v.we_cyc);
    check($sformatf("v%0d_first_we", idx), fw, v.first_we);
    check($sformatf("v%0d_addr", idx), addr_ok, 1);
    check($sformatf("v%0d_wdata", idx), wdata_ok, 1);
    req = 1'b0;
    @(negedge clk);
  endtask

  // Transaction model: tracks the cycle index within the current access.
  int          m_phase, m_len;
  bit          m_io, m_we, m_armed;
  logic [15:0] m_addr, m_wdata, m_mdr_in, m_hex;

  task automatic m_reset();
    m_phase = 0; m_len = 0; m_io = 0; m_we = 0; m_armed = 1;
    m_addr = '0; m_wdata = '0; m_mdr_in = '0; m_hex = '0;
  endtask

  task automatic m_edge();
    bit acc;
    acc = (m_phase == 0) && req && m_armed;
    if (!req) m_armed = 1;
    if (acc) begin
      m_armed = 0;
      m_io    = (mar == IO);
      m_we    = we;
      m_phase = 1;
      if (m_io) begin
        m_len = 1;
        if (we) m_hex = mdr;
        else    m_mdr_in = s;
      end else begin
        m_len   = L + 2;
        m_addr  = mar;
        m_wdata = mdr;
      end
    end else if (m_phase != 0) begin
      if (!m_io && !m_we && m_phase == L + 1) m_mdr_in = rdata;
      m_phase = (m_phase == m_len) ? 0 : m_phase + 1;
    end
  endtask

  initial begin
    int   rcount;
    bit   act;
    logic [6:0] exp_ctl;

    rst = 1'b1; req = 1'b0; we = 1'b0; mar = '0; mdr = '0; s = '0; rdata = '0;
    vecs[0] = '{1'b0, 16'h0123, 16'h0000, 16'h0000, 16'hBEEF, 4, 16'hBEEF, 16'h0000, 3, 3, 0, 0};
    vecs[1] = '{1'b1, 16'h3000, 16'h1234, 16'h0000, 16'h5555, 4, 16'hBEEF, 16'h0000, 3, 0, 2, 2};
    vecs[2] = '{1'b0, 16'hFFFF, 16'h9999, 16'h00A5, 16'h7777, 1, 16'h00A5, 16'h0000, 0, 0, 0, 0};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h4C33, 16'h1111, 16'h7777, 1, 16'h00A5, 16'h4C33, 0, 0, 0, 0};
    vecs[4] = '{1'b0, 16'hFFFE, 16'h2222, 16'h3333, 16'h1357, 4, 16'h1357, 16'h4C33, 3, 3, 0, 0};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 4, 16'h8001, 16'h4C33, 3, 3, 0, 0};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h0F0F, 16'h4444, 16'h0000, 1, 16'h8001, 16'h0F0F, 0, 0, 0, 0};
    vecs[7] = '{1'b1, 16'h7FFF, 16'hA5A5, 16'h0000, 16'h0000, 4, 16'h8001, 16'h0F0F, 3, 0, 2, 2};

    repeat (2) @(negedge clk);
    check("reset_r_busy", {r, busy}, 2'b00);
    check("reset_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    check("reset_mdr_in", mdr_in, 16'h0000);
    check("reset_hex", hex, 16'h0000);
    check("reset_addr", sram_addr, 20'h00000);
    check("reset_wdata", sram_wdata, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; consecutive rows also exercise back-to-back acceptance.
    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // Reset in the middle of a write's WAIT phase.
    req = 1'b1; we = 1'b1; mar = 16'h3000; mdr = 16'hAAAA;
    repeat (2) @(negedge clk);
    check("midrst_we_low_before", we_n, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_strobes", {ce_n, we_n, oe_n}, 3'b111);
    check("midrst_busy", busy, 1'b0);
    check("midrst_mdr_in", mdr_in, 16'h0000);
    check("midrst_hex", hex, 16'h0000);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (r) rcount++;
    end
    check("midrst_no_r", rcount, 0);

    // Request held high for 10 cycles yields exactly one access.
    req = 1'b1; we = 1'b0; mar = 16'h0200; rdata = 16'h1111;
    rcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (r) rcount++;
    end
    check("held_one_r", rcount, 1);
    check("held_busy_after", busy, 1'b0);
    check("held_mdr_in", mdr_in, 16'h1111);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1; rdata = 16'h2222;
    rcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (r) rcount++;
    end
    check("rearm_second_r", rcount, 1);
    check("rearm_mdr_in", mdr_in, 16'h2222);
    req = 1'b0;

    // Randomized traffic against the model.
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      act = !m_io && m_phase >= 1 && m_phase <= L + 1;
      exp_ctl = {m_phase != 0 && m_phase == m_len, m_phase != 0, !act, !(act && !m_we),
                 !(act && m_we && m_phase >= 2), !act, !act};
      check("rand_ctl", {r, busy, ce_n, oe_n, we_n, ub_n, lb_n}, exp_ctl);
      check("rand_mdr_in", mdr_in, m_mdr_in);
      check("rand_hex", hex, m_hex);
      if (m_phase != 0 && !m_io) begin
        check("rand_addr", sram_addr, ADDR_W'(m_addr));
        check("rand_wdata", sram_wdata, m_wdata);
      end
      req   = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1) != 0;
      mar   = ($urandom_range(0, 3) == 0) ? IO : 16'($urandom);
      mdr   = 16'($urandom);
      s     = 16'($urandom);
      rdata = 16'($urandom);
      @(posedge clk);
      m_edge();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
